// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the memory read/write arbiters: FSM state, bus owner,
// bundled AR/R channel structs and the grant-to-owner helper.
package mem_read_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    // Bit positions inside the one-hot grant vector from arb2_pick
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } arb_owner_e;

    // Read-address channel as seen from one master
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              valid;
    } ar_req_t;

    // Read-data channel as returned to one master
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
        logic              valid;
    } r_rsp_t;

    // Turn a one-hot grant into an owner code; no grant maps to OWN_NONE
    function automatic arb_owner_e grant_owner(input logic [1:0] grant);
        if (grant[GNT_LSU])      return OWN_LSU;
        else if (grant[GNT_IFU]) return OWN_IFU;
        else                     return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_arb2.sv
// Two-requester grant picker. A lone request always wins; on a tie the LSU
// wins in priority mode, otherwise whichever master was not granted last.
// A last grant of NONE counts as "not LSU", so the first tie goes to LSU.
module arb2_pick
    import mem_read_arbiter_pkg::*;
(
    input  logic       req_ifu,
    input  logic       req_lsu,
    input  logic       lsu_priority,
    input  arb_owner_e last_grant,
    output logic [1:0] grant
);

    // Combinational one-hot grant selection
    always_comb begin
        grant = '0;
        if (req_ifu && req_lsu) begin
            if (lsu_priority || (last_grant != OWN_LSU)) grant[GNT_LSU] = 1'b1;
            else                                          grant[GNT_IFU] = 1'b1;
        end else if (req_lsu) begin
            grant[GNT_LSU] = 1'b1;
        end else if (req_ifu) begin
            grant[GNT_IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Read arbiter joining the IFU and LSU read ports onto a single SRAM slave.
// One transaction at a time: IDLE (decide) -> ADDR (forward AR) -> DATA
// (forward R) -> IDLE. The slave-facing and owner-facing handshakes are
// combinational pass-throughs gated by the registered state and owner, so
// the arbiter adds no latency inside ADDR/DATA, only the IDLE decision cycle.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int LSU_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [RESP_W-1:0] ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [RESP_W-1:0] lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,

    output logic [ADDR_W-1:0] sram_araddr,
    output logic              sram_arvalid,
    input  logic              sram_arready,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic [RESP_W-1:0] sram_rresp,
    input  logic              sram_rvalid,
    output logic              sram_rready
);

    arb_state_e state_q;
    arb_owner_e owner_q;
    arb_owner_e last_q;

    logic [1:0] grant;
    arb_owner_e pick;

    ar_req_t ifu_ar;
    ar_req_t lsu_ar;
    ar_req_t own_ar;
    r_rsp_t  slave_r;
    r_rsp_t  ifu_r;
    r_rsp_t  lsu_r;

    logic in_addr;
    logic in_data;
    logic own_ifu;
    logic own_lsu;
    logic own_rready;

    assign ifu_ar  = '{addr: ifu_araddr, valid: ifu_arvalid};
    assign lsu_ar  = '{addr: lsu_araddr, valid: lsu_arvalid};
    assign slave_r = '{data: sram_rdata, resp: sram_rresp, valid: sram_rvalid};

    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);
    assign own_ifu = (owner_q == OWN_IFU);
    assign own_lsu = (owner_q == OWN_LSU);

    arb2_pick u_pick (
        .req_ifu      (ifu_arvalid),
        .req_lsu      (lsu_arvalid),
        .lsu_priority (LSU_PRIORITY != 0),
        .last_grant   (last_q),
        .grant        (grant)
    );

    assign pick = grant_owner(grant);

    // Transaction FSM: owner and last-grant are captured only in IDLE, so a
    // non-owner request simply waits for the next decision cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            last_q  <= OWN_IFU;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick != OWN_NONE) begin
                        owner_q <= pick;
                        last_q  <= pick;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sram_arvalid && sram_arready) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    // Any rresp ends the transaction; error retry is the master's job
                    if (sram_rvalid && sram_rready) begin
                        state_q <= ST_IDLE;
                        owner_q <= OWN_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Select the owner's AR request and R ready
    always_comb begin
        own_ar     = '0;
        own_rready = 1'b0;
        if (own_ifu) begin
            own_ar     = ifu_ar;
            own_rready = ifu_rready;
        end else if (own_lsu) begin
            own_ar     = lsu_ar;
            own_rready = lsu_rready;
        end
    end

    // AR path: forwarded only in ADDR, address forced to 0 elsewhere
    always_comb begin
        sram_araddr  = '0;
        sram_arvalid = 1'b0;
        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        if (in_addr) begin
            sram_araddr  = own_ar.addr;
            sram_arvalid = own_ar.valid;
            ifu_arready  = own_ifu && sram_arready;
            lsu_arready  = own_lsu && sram_arready;
        end
    end

    // R path: the slave response reaches only the owner, and only in DATA
    always_comb begin
        ifu_r       = '0;
        lsu_r       = '0;
        sram_rready = 1'b0;
        if (in_data) begin
            sram_rready = own_rready;
            if (own_ifu) ifu_r = slave_r;
            if (own_lsu) lsu_r = slave_r;
        end
    end

    assign ifu_rdata  = ifu_r.data;
    assign ifu_rresp  = ifu_r.resp;
    assign ifu_rvalid = ifu_r.valid;
    assign lsu_rdata  = lsu_r.data;
    assign lsu_rresp  = lsu_r.resp;
    assign lsu_rvalid = lsu_r.valid;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: one instance in LSU-priority mode driven by
// directed master tasks plus a reactive SRAM model, and one round-robin
// instance with both masters requesting back to back. Expected read data
// is queued per master when a request is issued and compared on R handshake.
module tb_mem_read_arbiter;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- priority-mode DUT ----------------
    logic [31:0] ifu_araddr = '0, lsu_araddr = '0;
    logic        ifu_arvalid = 1'b0, lsu_arvalid = 1'b0;
    logic        ifu_arready, lsu_arready;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp;
    logic        ifu_rvalid, lsu_rvalid;
    logic        ifu_rready = 1'b1, lsu_rready = 1'b1;
    logic [31:0] sram_araddr;
    logic        sram_arvalid;
    logic        sram_arready = 1'b1;
    logic [31:0] sram_rdata = '0;
    logic [1:0]  sram_rresp = '0;
    logic        sram_rvalid = 1'b0;
    logic        sram_rready;

    mem_read_arbiter #(.LSU_PRIORITY(1)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
        .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid), .sram_rready(sram_rready)
    );

    // ---------------- round-robin DUT ----------------
    logic        r0_ifu_arvalid = 1'b0, r0_lsu_arvalid = 1'b0;
    logic        r0_ifu_arready, r0_lsu_arready;
    logic [31:0] r0_ifu_rdata, r0_lsu_rdata;
    logic [1:0]  r0_ifu_rresp, r0_lsu_rresp;
    logic        r0_ifu_rvalid, r0_lsu_rvalid;
    logic [31:0] r0_sram_araddr;
    logic        r0_sram_arvalid;
    logic [31:0] r0_sram_rdata = '0;
    logic        r0_sram_rvalid = 1'b0;
    logic        r0_sram_rready;
    logic [31:0] r0_ifu_addr = 32'h0000_1000;
    logic [31:0] r0_lsu_addr = 32'h0000_2000;
    logic        one = 1'b1;
    logic [1:0]  zero2 = 2'b00;

    mem_read_arbiter #(.LSU_PRIORITY(0)) u_dut_rr (
        .clk(clk), .rst(rst),
        .ifu_araddr(r0_ifu_addr), .ifu_arvalid(r0_ifu_arvalid), .ifu_arready(r0_ifu_arready),
        .ifu_rdata(r0_ifu_rdata), .ifu_rresp(r0_ifu_rresp), .ifu_rvalid(r0_ifu_rvalid), .ifu_rready(one),
        .lsu_araddr(r0_lsu_addr), .lsu_arvalid(r0_lsu_arvalid), .lsu_arready(r0_lsu_arready),
        .lsu_rdata(r0_lsu_rdata), .lsu_rresp(r0_lsu_rresp), .lsu_rvalid(r0_lsu_rvalid), .lsu_rready(one),
        .sram_araddr(r0_sram_araddr), .sram_arvalid(r0_sram_arvalid), .sram_arready(one),
        .sram_rdata(r0_sram_rdata), .sram_rresp(zero2), .sram_rvalid(r0_sram_rvalid), .sram_rready(r0_sram_rready)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- SRAM models ----------------
    logic [1:0] resp_cfg = 2'd0;

    // Slave: returns data one cycle after AR handshake, holds until R handshake
    always @(posedge clk) begin
        if (rst) begin
            sram_rvalid <= 1'b0;
        end else begin
            if (sram_rvalid && sram_rready) sram_rvalid <= 1'b0;
            if (sram_arvalid && sram_arready) begin
                sram_rvalid <= 1'b1;
                sram_rdata  <= data_of(sram_araddr);
                sram_rresp  <= resp_cfg;
            end
        end
    end

    // Same slave behaviour for the round-robin instance
    always @(posedge clk) begin
        if (rst) begin
            r0_sram_rvalid <= 1'b0;
        end else begin
            if (r0_sram_rvalid && r0_sram_rready) r0_sram_rvalid <= 1'b0;
            if (r0_sram_arvalid) begin
                r0_sram_rvalid <= 1'b1;
                r0_sram_rdata  <= data_of(r0_sram_araddr);
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    exp_t ifu_q[$];
    exp_t lsu_q[$];
    bit   order_q[$];      // 1 = LSU completed, 0 = IFU completed
    int   r_count = 0;
    int   lsu_vld_cycles = 0;
    int   r_cyc_lsu = 0;
    int   ar_cyc_ifu = 0;
    bit   rr_gnt[$];       // 1 = LSU granted on round-robin instance
    int   rr_cyc[$];

    always @(negedge clk) begin
        exp_t e;
        if (lsu_rvalid) lsu_vld_cycles++;
        if (ifu_rvalid && ifu_rready) begin
            r_count++;
            order_q.push_back(1'b0);
            if (ifu_q.size() == 0) chk("ifu_unexpected_r", 1, 0);
            else begin
                e = ifu_q.pop_front();
                chk("ifu_rdata", ifu_rdata, e.data);
                chk("ifu_rresp", ifu_rresp, e.resp);
            end
        end
        if (lsu_rvalid && lsu_rready) begin
            r_count++;
            r_cyc_lsu = cyc;
            order_q.push_back(1'b1);
            if (lsu_q.size() == 0) chk("lsu_unexpected_r", 1, 0);
            else begin
                e = lsu_q.pop_front();
                chk("lsu_rdata", lsu_rdata, e.data);
                chk("lsu_rresp", lsu_rresp, e.resp);
            end
        end
        if (r0_sram_arvalid) begin
            rr_gnt.push_back(r0_lsu_arready);
            rr_cyc.push_back(cyc);
        end
    end

    // ---------------- master driver ----------------
    task automatic issue(input bit lsu, input logic [31:0] addr);
        exp_t e;
        bit   hs = 1'b0;
        e.data = data_of(addr);
        e.resp = resp_cfg;
        if (lsu) begin lsu_q.push_back(e); lsu_araddr = addr; lsu_arvalid = 1'b1; end
        else     begin ifu_q.push_back(e); ifu_araddr = addr; ifu_arvalid = 1'b1; end
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk);
            hs = lsu ? lsu_arready : ifu_arready;
            if (hs && !lsu) ar_cyc_ifu = cyc;
            @(posedge clk);
        end
        if (!hs) chk(lsu ? "lsu_ar_timeout" : "ifu_ar_timeout", 0, 1);
        #1;
        if (lsu) begin lsu_arvalid = 1'b0; lsu_araddr = '0; end
        else     begin ifu_arvalid = 1'b0; ifu_araddr = '0; end
    endtask

    task automatic drain();
        int k = 0;
        while ((ifu_q.size() != 0 || lsu_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic any_out();
        return |{ifu_arready, lsu_arready, ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp,
                 ifu_rvalid, lsu_rvalid, sram_araddr, sram_arvalid, sram_rready};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int base, rc0;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs_zero", any_out(), 0);
        chk("rst_rr_outputs_zero", |{r0_ifu_arready, r0_lsu_arready, r0_sram_arvalid, r0_sram_araddr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin: continuous tie -> LSU, IFU, LSU, IFU, three cycles apart
        r0_ifu_arvalid = 1'b1;
        r0_lsu_arvalid = 1'b1;
        for (int k = 0; k < 60 && rr_gnt.size() < 4; k++) @(negedge clk);
        r0_ifu_arvalid = 1'b0;
        r0_lsu_arvalid = 1'b0;
        chk("rr_grant_count", (rr_gnt.size() >= 4), 1);
        if (rr_gnt.size() >= 4) begin
            chk("rr_grant0_lsu", rr_gnt[0], 1);
            chk("rr_grant1_ifu", rr_gnt[1], 0);
            chk("rr_grant2_lsu", rr_gnt[2], 1);
            chk("rr_grant3_ifu", rr_gnt[3], 0);
            for (int i = 1; i < 4; i++) chk("rr_grant_spacing", rr_cyc[i] - rr_cyc[i-1], 3);
        end
        repeat (4) @(posedge clk); #1;

        // IFU-only read
        base = lsu_vld_cycles;
        issue(1'b0, 32'h8000_0000);
        drain();
        chk("ifu_only_lsu_rvalid_quiet", lsu_vld_cycles - base, 0);
        chk("ifu_only_araddr_zero", sram_araddr, 0);

        // Tie in priority mode: LSU first, IFU granted two cycles after LSU R handshake
        order_q.delete();
        fork
            issue(1'b1, 32'h0000_3000);
            issue(1'b0, 32'h0000_4000);
        join
        drain();
        chk("tie_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk("tie_first_lsu", order_q[0], 1);
            chk("tie_second_ifu", order_q[1], 0);
        end
        chk("tie_ifu_grant_gap", ar_cyc_ifu - r_cyc_lsu, 2);

        // Backpressure on AR then on R
        rc0 = r_count;
        sram_arready = 1'b0;
        ifu_rready   = 1'b0;
        fork
            issue(1'b0, 32'h1000_0040);
            begin
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = sram_arvalid;
                end
                chk("bp_ar_seen", seen, 1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_ifu_arready_low", ifu_arready, 0);
                    chk("bp_sram_arvalid", sram_arvalid, 1);
                    chk("bp_sram_araddr", sram_araddr, 32'h1000_0040);
                end
                @(posedge clk); #1;
                sram_arready = 1'b1;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = sram_rvalid;
                end
                chk("bp_r_seen", seen, 1);
                for (int i = 0; i < 2; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_ifu_rvalid_held", ifu_rvalid, 1);
                    chk("bp_ifu_rdata_stable", ifu_rdata, data_of(32'h1000_0040));
                    chk("bp_sram_rready_low", sram_rready, 0);
                end
                @(posedge clk); #1;
                ifu_rready = 1'b1;
            end
        join
        drain();
        chk("bp_one_completion", r_count - rc0, 1);

        // Error response to LSU, then a normal LSU read
        resp_cfg = 2'd2;
        issue(1'b1, 32'h0000_5000);
        drain();
        resp_cfg = 2'd0;
        issue(1'b1, 32'h0000_5004);
        drain();

        // Reset while in DATA, then a clean IFU read
        rc0 = r_count;
        ifu_rready = 1'b0;
        issue(1'b0, 32'h0000_6000);
        @(negedge clk);
        chk("rst_data_rvalid_pending", ifu_rvalid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_data_outputs_zero", any_out(), 0);
        rst = 1'b0;
        ifu_q.delete();
        ifu_rready = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_data_no_completion", r_count - rc0, 0);
        issue(1'b0, 32'h8000_0000);
        drain();
        chk("post_rst_completion", r_count - rc0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter LSU_PRIORITY, default 1; 1 = LSU always wins ties, 0 = round-robin on ties.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports ifu_araddr and lsu_araddr, input, 32, master read addresses.
REQ-005 SHALL have ports ifu_arvalid and lsu_arvalid, input, 1, master AR valid.
REQ-006 SHALL have ports ifu_arready and lsu_arready, output, 1, AR ready to master.
REQ-007 SHALL have ports ifu_rdata and lsu_rdata, output, 32, read data to master.
REQ-008 SHALL have ports ifu_rresp and lsu_rresp, output, 2, read response to master.
REQ-009 SHALL have ports ifu_rvalid and lsu_rvalid, output, 1, R valid to master.
REQ-010 SHALL have ports ifu_rready and lsu_rready, input, 1, R ready from master.
REQ-011 SHALL have port sram_araddr, output, 32, forwarded address.
REQ-012 SHALL have ports sram_arvalid (output, 1) and sram_arready (input, 1), slave AR handshake.
REQ-013 SHALL have ports sram_rdata (input, 32) and sram_rresp (input, 2), slave read return.
REQ-014 SHALL have ports sram_rvalid (input, 1) and sram_rready (output, 1), slave R handshake.

Function
REQ-015 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with a registered owner (NONE/IFU/LSU).
REQ-016 IDLE: if exactly one arvalid is high, SHALL register that master as owner and go to ADDR next cycle.
REQ-017 IDLE, both arvalid high: LSU_PRIORITY=1 -> grant LSU; LSU_PRIORITY=0 -> grant the master not granted last (first tie after reset -> LSU).
REQ-018 IDLE: all master-facing ready/valid outputs SHALL be 0 and sram_arvalid SHALL be 0; no request is accepted during the decision cycle.
REQ-019 ADDR: sram_araddr and sram_arvalid SHALL combinationally follow the owner's araddr and arvalid; the owner's arready SHALL equal sram_arready; the non-owner's arready SHALL be 0.
REQ-020 ADDR: on sram_arvalid && sram_arready, SHALL go to DATA; otherwise SHALL stay in ADDR.
REQ-021 DATA: the owner's rvalid, rdata and rresp SHALL follow the sram signals; sram_rready SHALL equal the owner's rready; the non-owner's rvalid SHALL be 0 and its rdata and rresp SHALL be 0.
REQ-022 DATA: on sram_rvalid && sram_rready, SHALL return to IDLE with owner NONE, whatever the rresp value; the arbiter does not retry.
REQ-023 A non-owner's pending arvalid SHALL be held off (arready 0) until the next IDLE decision, and no transaction SHALL be dropped.
REQ-024 Minimum occupancy SHALL be 3 cycles per transaction (IDLE, ADDR, DATA); back-to-back transactions SHALL insert exactly one IDLE cycle.
REQ-025 sram_araddr SHALL be 0 whenever the state is not ADDR.
REQ-026 At most one read SHALL be outstanding at the slave at any time.

Reset
REQ-027 rst high SHALL force state IDLE, owner NONE and last-grant IFU (so the next tie goes to LSU) on the next posedge, including mid-ADDR or mid-DATA.
REQ-028 During and after reset, every output SHALL be 0 until a new grant is made.

Structure
REQ-029 The state enum (IDLE/ADDR/DATA) and owner enum (NONE/IFU/LSU) SHALL live in a shared package, reused by the future write arbiter.
REQ-030 Grant selection SHALL be one sub-module, arb2_pick: inputs are two requests, a priority mode and the last grant; output is a one-hot grant.

Verification
REQ-031 IFU-only read: ifu_araddr=0x80000000, sram returns 0x00000413 with rresp=0 -> ifu_rdata=0x00000413; lsu_rvalid stays 0 throughout.
REQ-032 Tie with LSU_PRIORITY=1: both arvalid high in the same cycle -> LSU served first, IFU granted after the IDLE cycle that follows LSU's R handshake.
REQ-033 Tie with LSU_PRIORITY=0, both masters requesting continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU.
REQ-034 Backpressure: sram_arready low for 3 cycles, then ifu_rready low for 2 cycles while sram_rvalid is high -> owner stays the same, signals stay stable, and exactly one transaction completes.
REQ-035 rresp=2 returned to LSU -> lsu_rresp=2, FSM returns to IDLE, and the next request is served normally.
REQ-036 rst asserted in DATA -> next cycle all outputs 0 and state IDLE; a subsequent IFU read completes correctly.
